// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encodings, opcode bit positions and the ID->EX bus layout
// for the execute stage and its iterative divider.
package ex_stage_pkg;

   localparam int EX_TO_MEM_WD = 76;
   localparam int EX_TO_ID_WD  = 38;
   localparam int STALL_BUS    = 6;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // alu_op is one-hot, MSB first: {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
   localparam int ALU_ADD  = 11;
   localparam int ALU_SUB  = 10;
   localparam int ALU_SLT  = 9;
   localparam int ALU_SLTU = 8;
   localparam int ALU_AND  = 7;
   localparam int ALU_NOR  = 6;
   localparam int ALU_OR   = 5;
   localparam int ALU_XOR  = 4;
   localparam int ALU_SLL  = 3;
   localparam int ALU_SRL  = 2;
   localparam int ALU_SRA  = 1;
   localparam int ALU_LUI  = 0;

   localparam int MD_DIV  = 3;
   localparam int MD_DIVU = 2;
   localparam int MD_MFHI = 1;
   localparam int MD_MFLO = 0;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [11:0] alu_op;
      logic [3:0]  md_op;
      logic        ram_en;
      logic [3:0]  ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] st_data;
   } id_to_ex_t;

   localparam int ID_TO_EX_WD = $bits(id_to_ex_t);

   function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Restoring divider, one quotient bit per cycle: IDLE -> BUSY (32 cycles) -> DONE (1 cycle).
// Works on magnitudes and fixes signs when presenting the result in DONE.
module div_iter
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   div_state_e  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] dvd_q, dvd_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;
   logic        zero_q, zero_d;
   logic [32:0] trial;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DIV_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DIV_IDLE: if (start) state_d = DIV_BUSY;
         DIV_BUSY: if (cnt_q == 5'd31) state_d = DIV_DONE;
         DIV_DONE: state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == DIV_BUSY);
      done      = (state_q == DIV_DONE);
      quotient  = '0;
      remainder = '0;
      if (state_q == DIV_DONE) begin
         if (zero_q) begin
            quotient  = '1;
            remainder = dvd_q;
         end else begin
            quotient  = q_neg_q ? -quo_q : quo_q;
            remainder = r_neg_q ? -rem_q : rem_q;
         end
      end
   end

   // Partial remainder stays below the divisor, so bit 32 of the trial is the borrow.
   assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};

   always_comb begin
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      dvd_d   = dvd_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      zero_d  = zero_q;
      if (state_q == DIV_IDLE && start) begin
         cnt_d   = '0;
         rem_d   = '0;
         quo_d   = abs32(dividend, is_signed & dividend[31]);
         dvs_d   = abs32(divisor, is_signed & divisor[31]);
         dvd_d   = dividend;
         q_neg_d = is_signed & (dividend[31] ^ divisor[31]);
         r_neg_d = is_signed & dividend[31];
         zero_d  = (divisor == 32'd0);
      end else if (state_q == DIV_BUSY) begin
         cnt_d = cnt_q + 5'd1;
         if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
         end else begin
            rem_d = {rem_q[30:0], quo_q[31]};
            quo_d = {quo_q[30:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      zero_q  <= zero_d;
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID->EX input register, one-hot ALU, HI/LO with iterative divide,
// data SRAM request and forwarding/MEM bus packing.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_BUS-1:0]    stall,
   input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
   output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
   output logic                    ex_is_load,
   output logic                    stallreq_for_ex,
   output logic                    data_sram_en,
   output logic [3:0]              data_sram_wen,
   output logic [31:0]             data_sram_addr,
   output logic [31:0]             data_sram_wdata
);

   id_to_ex_t          ex_q, ex_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic               seen_q, seen_d;
   logic               load;
   logic               div_start, div_busy, div_done;
   logic [31:0]        div_quo, div_rem;
   logic [31:0]        hi_cur, lo_cur;
   logic [31:0]        alu_res, ex_result;
   logic signed [31:0] src2_s;
   logic [4:0]         sh;
   logic               unused_stall;

   assign unused_stall = ^{stall[5:4], stall[1:0]};
   assign load         = (stall[2] == NO_STOP);

   // EX stalled while MEM advances: insert a bubble rather than duplicate the op.
   always_comb begin
      ex_d = ex_q;
      if (stall[2] == STOP && stall[3] == NO_STOP) begin
         ex_d = '0;
      end else if (load) begin
         ex_d = id_to_ex_t'(id_to_ex_bus);
      end
   end

   // seen_q stops a finished divide that is still held in EX from restarting.
   assign div_start = (ex_q.md_op[MD_DIV] | ex_q.md_op[MD_DIVU])
                      & ~div_busy & ~div_done & ~seen_q;
   assign stallreq_for_ex = div_start | div_busy;

   div_iter u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .is_signed (ex_q.md_op[MD_DIV]),
      .dividend  (ex_q.src1),
      .divisor   (ex_q.src2),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   assign hi_cur = div_done ? div_rem : hi_q;
   assign lo_cur = div_done ? div_quo : lo_q;
   assign hi_d   = hi_cur;
   assign lo_d   = lo_cur;
   assign seen_d = load ? 1'b0 : (div_done ? 1'b1 : seen_q);

   assign src2_s = ex_q.src2;
   assign sh     = ex_q.src1[4:0];

   always_comb begin
      alu_res = '0;
      if (ex_q.alu_op[ALU_ADD])  alu_res |= ex_q.src1 + ex_q.src2;
      if (ex_q.alu_op[ALU_SUB])  alu_res |= ex_q.src1 - ex_q.src2;
      if (ex_q.alu_op[ALU_SLT])  alu_res |= {31'd0, $signed(ex_q.src1) < $signed(ex_q.src2)};
      if (ex_q.alu_op[ALU_SLTU]) alu_res |= {31'd0, ex_q.src1 < ex_q.src2};
      if (ex_q.alu_op[ALU_AND])  alu_res |= ex_q.src1 & ex_q.src2;
      if (ex_q.alu_op[ALU_NOR])  alu_res |= ~(ex_q.src1 | ex_q.src2);
      if (ex_q.alu_op[ALU_OR])   alu_res |= ex_q.src1 | ex_q.src2;
      if (ex_q.alu_op[ALU_XOR])  alu_res |= ex_q.src1 ^ ex_q.src2;
      if (ex_q.alu_op[ALU_SLL])  alu_res |= ex_q.src2 << sh;
      if (ex_q.alu_op[ALU_SRL])  alu_res |= ex_q.src2 >> sh;
      if (ex_q.alu_op[ALU_SRA])  alu_res |= 32'(src2_s >>> sh);
      if (ex_q.alu_op[ALU_LUI])  alu_res |= {ex_q.src2[15:0], 16'h0000};
   end

   always_comb begin
      ex_result = alu_res;
      if (ex_q.md_op[MD_MFHI]) begin
         ex_result = hi_cur;
      end else if (ex_q.md_op[MD_MFLO]) begin
         ex_result = lo_cur;
      end
   end

   assign ex_to_mem_bus = {ex_q.pc, ex_q.ram_en, ex_q.ram_wen, ex_q.sel_rf_res,
                           ex_q.rf_we, ex_q.rf_waddr, ex_result};
   assign ex_to_id_bus  = {ex_q.rf_we, ex_q.rf_waddr, ex_result};
   assign ex_is_load    = ex_q.ram_en & ex_q.sel_rf_res & ~|ex_q.ram_wen;

   assign data_sram_en    = ex_q.ram_en;
   assign data_sram_wen   = ex_q.ram_wen;
   assign data_sram_addr  = ex_result;
   assign data_sram_wdata = ex_q.st_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q   <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         seen_q <= 1'b0;
      end else begin
         ex_q   <= ex_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         seen_q <= seen_d;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: an abstract reference (plain arithmetic, cycle-count view of
// the divide) is compared every cycle, plus hand-computed literal expectations.
module tb_ex_stage;

   localparam int IDW = 156;

   logic             clk = 1'b0;
   logic             rst;
   logic [5:0]       stall_tb;
   logic [5:0]       stall;
   logic [IDW-1:0]   id_bus;
   logic [75:0]      ex_to_mem_bus;
   logic [37:0]      ex_to_id_bus;
   logic             ex_is_load, stallreq_for_ex, data_sram_en;
   logic [3:0]       data_sram_wen;
   logic [31:0]      data_sram_addr, data_sram_wdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .id_to_ex_bus    (id_bus),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .ex_to_id_bus    (ex_to_id_bus),
      .ex_is_load      (ex_is_load),
      .stallreq_for_ex (stallreq_for_ex),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200,
                           OP_SLTU = 12'h100, OP_AND = 12'h080, OP_NOR = 12'h040,
                           OP_OR = 12'h020, OP_XOR = 12'h010, OP_SLL = 12'h008,
                           OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI = 12'h001;
   localparam logic [3:0]  MD_DIV = 4'b1000, MD_DIVU = 4'b0100,
                           MD_MFHI = 4'b0010, MD_MFLO = 4'b0001;

   function automatic logic [IDW-1:0] mk(input logic [31:0] pc, input logic [11:0] alu,
                                         input logic [3:0] md, input logic ren,
                                         input logic [3:0] wen, input logic sel,
                                         input logic we, input logic [4:0] wa,
                                         input logic [31:0] s1, input logic [31:0] s2,
                                         input logic [31:0] st);
      return {pc, alu, md, ren, wen, sel, we, wa, s1, s2, st};
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [31:0] bs;
      bs = b;
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
         OP_AND:  return a & b;
         OP_NOR:  return ~(a | b);
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLL:  return b << a[4:0];
         OP_SRL:  return b >> a[4:0];
         OP_SRA:  return 32'(bs >>> a[4:0]);
         OP_LUI:  return {b[15:0], 16'h0000};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (!sgn) begin
         q = a / b; r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'd0;
      end else begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
      end
      return {r, q};
   endfunction

   logic [IDW-1:0] m_bus;
   logic [31:0]    m_hi, m_lo, m_dq, m_dr;
   int             m_age;       // cycles elapsed since the divide started; 0 = none
   logic           m_seen;
   logic           m_start, m_stallreq;
   logic [31:0]    e_hi, e_lo, e_res;

   assign m_start    = (m_bus[111] | m_bus[110]) && (m_age == 0) && !m_seen;
   assign m_stallreq = m_start || (m_age >= 1 && m_age <= 32);
   // Pipeline controller: a stall request from EX freezes IF..MEM inputs.
   assign stall      = stall_tb | (m_stallreq ? 6'b001111 : 6'b000000);

   always_comb begin
      e_hi  = (m_age == 33) ? m_dr : m_hi;
      e_lo  = (m_age == 33) ? m_dq : m_lo;
      e_res = alu_ref(m_bus[123:112], m_bus[95:64], m_bus[63:32]);
      if (m_bus[109])      e_res = e_hi;
      else if (m_bus[108]) e_res = e_lo;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_bus <= '0; m_hi <= '0; m_lo <= '0; m_age <= 0; m_seen <= 1'b0;
      end else begin
         if (stall[2] && !stall[3]) m_bus <= '0;
         else if (!stall[2])        m_bus <= id_bus;
         if (m_start) begin
            m_age <= 1;
            {m_dr, m_dq} <= div_ref(m_bus[95:64], m_bus[63:32], m_bus[111]);
         end else if (m_age >= 1 && m_age <= 32) begin
            m_age <= m_age + 1;
         end else if (m_age == 33) begin
            m_age <= 0; m_hi <= m_dr; m_lo <= m_dq;
         end
         if (!stall[2])         m_seen <= 1'b0;
         else if (m_age == 33)  m_seen <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("mem_bus", ex_to_mem_bus, {m_bus[155:124], m_bus[107], m_bus[106:103],
                                     m_bus[102], m_bus[101], m_bus[100:96], e_res});
      chk("id_bus", 76'(ex_to_id_bus), 76'({m_bus[101], m_bus[100:96], e_res}));
      chk("is_load", 76'(ex_is_load), 76'(m_bus[107] & m_bus[102] & ~|m_bus[106:103]));
      chk("stallreq", 76'(stallreq_for_ex), 76'(m_stallreq));
      chk("sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
          76'({m_bus[107], m_bus[106:103], e_res, m_bus[31:0]}));
   end

   // ---------------- directed stimulus ----------------
   task automatic issue(input logic [IDW-1:0] b);
      id_bus = b;
      @(posedge clk); #1;
   endtask

   task automatic alu_case(input string name, input logic [11:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
      issue(mk(32'h300, op, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 5'd9, a, b, 32'd0));
      chk(name, 76'(ex_to_id_bus[31:0]), 76'(exp));
   endtask

   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
      int n;
      issue(mk(32'h200, 12'h0, sgn ? MD_DIV : MD_DIVU, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0,
               a, b, 32'd0));
      id_bus = mk(32'h204, 12'h0, MD_MFLO, 1'b0, 4'h0, 1'b1, 1'b1, 5'd8, 0, 0, 0);
      n = 0;
      while (stallreq_for_ex && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      chk("div_stall_cycles", 76'(n), 76'(33));
      @(posedge clk); #1;
      chk("mflo", 76'(ex_to_id_bus[31:0]), 76'(exp_lo));
      issue(mk(32'h208, 12'h0, MD_MFHI, 1'b0, 4'h0, 1'b1, 1'b1, 5'd9, 0, 0, 0));
      chk("mfhi", 76'(ex_to_id_bus[31:0]), 76'(exp_hi));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; stall_tb = 6'b0; id_bus = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_bus", ex_to_mem_bus, 76'd0);
      chk("rst_stallreq", 76'(stallreq_for_ex), 76'd0);
      chk("rst_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), 76'd0);
      rst = 1'b0;

      // add wraps: 7 + 0xFFFFFFFF = 6
      issue(mk(32'h100, OP_ADD, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 5'd3,
               32'd7, 32'hFFFF_FFFF, 32'd0));
      chk("add_id_bus", 76'(ex_to_id_bus), 76'({1'b1, 5'd3, 32'd6}));
      chk("add_sram_en", 76'(data_sram_en), 76'd0);
      chk("add_mem_bus", ex_to_mem_bus,
          {32'h100, 1'b0, 4'h0, 1'b1, 1'b1, 5'd3, 32'd6});

      alu_case("sub",  OP_SUB,  32'd3, 32'd5, 32'hFFFF_FFFE);
      alu_case("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1);
      alu_case("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
      alu_case("and",  OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
      alu_case("nor",  OP_NOR,  32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF);
      alu_case("or",   OP_OR,   32'h0000_1200, 32'h0000_0034, 32'h0000_1234);
      alu_case("xor",  OP_XOR,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
      alu_case("sll",  OP_SLL,  32'd4, 32'd1, 32'd16);
      alu_case("srl",  OP_SRL,  32'd4, 32'h8000_0000, 32'h0800_0000);
      alu_case("sra",  OP_SRA,  32'd4, 32'h8000_0000, 32'hF800_0000);
      alu_case("lui",  OP_LUI,  32'd0, 32'h0000_1234, 32'h1234_0000);

      // stall behaviour: hold, then bubble
      issue(mk(32'h110, OP_ADD, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 5'd4, 32'd1, 32'd2, 32'd0));
      chk("pre_stall", 76'(ex_to_id_bus[31:0]), 76'd3);
      id_bus = mk(32'h114, OP_ADD, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 5'd5, 32'd10, 32'd20, 32'd0);
      stall_tb = 6'b001100;
      @(posedge clk); #1;
      chk("stall_hold", 76'(ex_to_id_bus), 76'({1'b1, 5'd4, 32'd3}));
      stall_tb = 6'b000100;
      @(posedge clk); #1;
      chk("stall_bubble", ex_to_mem_bus, 76'd0);
      stall_tb = 6'b000000;

      // store then load
      issue(mk(32'h120, OP_ADD, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0,
               32'h0000_1000, 32'd4, 32'h0000_CAFE));
      chk("sw_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
          76'({1'b1, 4'hF, 32'h0000_1004, 32'h0000_CAFE}));
      chk("sw_is_load", 76'(ex_is_load), 76'd0);
      issue(mk(32'h124, OP_ADD, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6,
               32'h0000_1000, 32'd4, 32'd0));
      chk("lw_is_load", 76'(ex_is_load), 76'd1);

      // divides
      run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
      run_div(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

      // reset in the middle of a divide
      issue(mk(32'h400, 12'h0, MD_DIVU, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0,
               32'd1000, 32'd3, 32'd0));
      id_bus = '0;
      repeat (10) begin
         @(posedge clk); #1;
      end
      chk("busy_before_rst", 76'(stallreq_for_ex), 76'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_div_stallreq", 76'(stallreq_for_ex), 76'd0);
      issue(mk(32'h404, 12'h0, MD_MFHI, 1'b0, 4'h0, 1'b1, 1'b1, 5'd1, 0, 0, 0));
      chk("rst_hi", 76'(ex_to_id_bus[31:0]), 76'd0);
      issue(mk(32'h408, 12'h0, MD_MFLO, 1'b0, 4'h0, 1'b1, 1'b1, 5'd2, 0, 0, 0));
      chk("rst_lo", 76'(ex_to_id_bus[31:0]), 76'd0);
      run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

      issue('0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
